lsu_mem_initiator: RTL

- Load/store unit that initiates all data-memory transactions for the core.
- Accepts one load/store per request handshake from the execute stage, with byte address, funct3 size and store data.
- Drives a word-organised, byte-enabled, synchronous-read data memory. Splits misaligned accesses into two word accesses.
- Returns aligned, sign- or zero-extended load data through a response handshake.

---
 rtl/lsu_mem_initiator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_initiator.sv
// Load/store unit front end: accepts one load/store from execute, drives a
// word-organised byte-enabled synchronous-read data memory (splitting
// misaligned accesses into two word accesses) and returns extended load data.
module lsu_mem_initiator #(
  parameter int ADDR_W  = 9,
  parameter int WORD_AW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_REQ1,
    S_DONE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       lo_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [1:0]         off;
  logic [3:0]         sizeMask;
  logic [7:0]         sh;
  logic               split;
  logic [4:0]         rotAmt;
  logic [5:0]         rotInv;
  logic [31:0]        rotWdata;
  logic [WORD_AW-1:0] wordAddr;
  logic [WORD_AW-1:0] wordAddrNext;
  logic [31:0]        loWord;
  logic [31:0]        hiWord;
  logic [31:0]        shifted;
  logic [31:0]        loadResult;
  logic               reqLegal;

  assign off          = addr_q[1:0];
  assign sh           = {4'b0000, sizeMask} << off;
  assign split        = |sh[7:4];
  assign rotAmt       = {off, 3'b000};
  assign rotInv       = 6'd32 - {1'b0, rotAmt};
  assign rotWdata     = (wdata_q << rotAmt) | (wdata_q >> rotInv);
  assign wordAddr     = addr_q[ADDR_W-1:2];
  assign wordAddrNext = wordAddr + WORD_AW'(1);

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Decode access size into a byte mask and check the incoming funct3
  always_comb begin
    sizeMask = 4'b1111;
    reqLegal = 1'b0;
    case (funct3_q[1:0])
      2'b00:   sizeMask = 4'b0001;
      2'b01:   sizeMask = 4'b0011;
      default: sizeMask = 4'b1111;
    endcase
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: reqLegal = 1'b1;
      default:                                reqLegal = 1'b0;
    endcase
  end

  // Align the returned word(s) down to lane 0 and extend to 32 bits
  always_comb begin
    loWord     = split ? lo_q : mem_rdata;
    hiWord     = split ? mem_rdata : 32'h0;
    shifted    = (loWord >> rotAmt) | (hiWord << rotInv);
    loadResult = shifted;
    case (funct3_q)
      3'b000:  loadResult = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadResult = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadResult = {24'h0, shifted[7:0]};
      3'b101:  loadResult = {16'h0, shifted[15:0]};
      default: loadResult = shifted;
    endcase
    if (we_q) begin
      loadResult = 32'h0;
    end
  end

  // Next-state and memory-port drive; strobes drop as soon as reset is seen
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = reqLegal ? S_REQ0 : S_RESP;
        end
      end
      S_REQ0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = wordAddr;
        mem_be    = sh[3:0];
        mem_wdata = rotWdata;
        state_d   = split ? S_REQ1 : S_DONE;
      end
      S_REQ1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = wordAddrNext;
        mem_be    = sh[7:4];
        mem_wdata = rotWdata;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mem_be  = 4'b0000;
    end
  end

  // State register plus request latch, low-word capture and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'h0;
      lo_q     <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            if (!reqLegal) begin
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end
          end
        end
        S_REQ1: begin
          lo_q <= mem_rdata;
        end
        S_DONE: begin
          rdata_q <= loadResult;
        end
        S_RESP: begin
          if (rsp_ready) begin
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
